fp_mul_seq: RTL
===============

Name: fp_mul_seq

Overview:
- Iterative single-precision IEEE-754 multiplier; the multiplicative counterpart of the sequential divider.
- Same act/done request interface, same rounding-mode selector and same exception flag set, so the FPU top level can issue to either unit identically.
- Shift-add mantissa datapath with a control FSM, then normalise, round and a registered output.

Parameters:
- W, 32, total word width.
- M, 22, MSB index of the stored fraction.
- E, 30, MSB index of the exponent field.
- BIAS, 127, exponent bias.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- act  in  1  start request; sampled only in IDLE.
- in1  in  W  multiplicand.
- in2  in  W  multiplier.
- round_m  in  3  rounding mode; shared macros `RNe, `RZ, `RU, `RD, `RNa.
- out  out  W  product.
- done  out  1  one-cycle pulse when out and flags are valid.
- ov  out  1  overflow.
- un  out  1  underflow.
- inv  out  1  invalid operation.
- inexact  out  1  result was rounded.

Behaviour:
- Reset (async, rst=0): FSM goes to IDLE; out=0, done=0, ov=0, un=0, inv=0, inexact=0; all datapath registers cleared.
- Reset mid-operation aborts the operation; no done is produced.
- FSM states: IDLE, SPECIAL, MUL, NORM, ROUND.
- IDLE, act=1 at edge k:
  - Capture in1, in2 and round_m.
  - Sign = S1^S2.
  - Exponent sum = E1+E2-BIAS, held in an 10-bit signed register.
  - Mantissas {1,frac}.
  - Go to SPECIAL if either operand is zero, inf or NaN, otherwise go to MUL.
- Special-operand rules:
  - Exponent field 0 counts as zero; subnormal inputs are flushed to zero.
  - Any NaN, or inf*0: out=0x7FC00000, inv=1.
  - inf*finite or inf*inf: signed inf.
  - zero*finite: signed zero.
  - In all these cases ov, un and inexact are 0.
- SPECIAL: results are registered; done asserts during the cycle after edge k+2 (2-cycle latency).
- MUL:
  - 24 iterations, one multiplier bit per cycle, 48-bit product accumulator.
  - A 5-bit counter counts 0..23, then the FSM goes to NORM.
- NORM:
  - If product[47]=1: shift right by 1, exponent+1.
  - Keep 24 mantissa bits, guard bit g, and sticky t = OR of all lower bits.
- ROUND: applies the same mode semantics as the divider:
  - RNe: increment if g&(t|lsb).
  - RNa: increment if g.
  - RZ: truncate.
  - RU: increment if (g|t) and the result is positive.
  - RD: increment if (g|t) and the result is negative.
  - Mantissa carry-out renormalises and sets exponent+1.
  - inexact = g|t.
- Overflow and underflow:
  - Final exponent >254: out = signed inf, ov=1, inexact=1.
  - Final exponent <1: out = signed zero, un=1, inexact=1.
- Normal-path latency: act at edge k gives done high during the cycle after edge k+27. Outputs are updated on that same edge.
- After done:
  - The FSM returns to IDLE.
  - out and flags hold until the next operation completes.
  - done is high for exactly one cycle.
- act while not in IDLE is ignored; there is no queueing.
- act asserted in the same cycle that done pulses is ignored; the unit accepts act from the following cycle.
- act held high continuously starts back-to-back operations, one per accept.

Optional Feature:
- Macro FP_MUL_RADIX4_EN.
- When defined, MUL retires two multiplier bits per cycle:
  - 12 iterations, 4-bit counter.
  - Normal-path latency becomes k+15.
  - SPECIAL latency is unchanged.
  - Results and flags are bit-identical to the radix-2 build.
- When undefined: radix-2, 24 iterations, latency k+27.

Test Plan:
- 0x3FC00000 * 0x40000000, RNe → out=0x40400000, inexact=0, done exactly 27 cycles after act, single-cycle pulse.
- 0x3F800001 * 0x3F800001:
  - RNe → 0x3F800002, inexact=1.
  - RU → 0x3F800003.
  - RZ → 0x3F800002.
- 0xC0000000 * 0x40400000 → 0xC0C00000, flags 0; then 0x7F000000 * 0x40000000 → 0x7F800000, ov=1, inexact=1.
- 0x7F800000 * 0x00000000 → 0x7FC00000, inv=1, done 2 cycles after act; 0x00800000 * 0x3F000000 → 0x00000000, un=1.
- act pulsed at cycles 5 and 10 with different operands → only the first result is produced; rst=0 at cycle 12 of an operation → outputs 0 and no done; a new act after reset completes normally.
- FP_MUL_RADIX4_EN defined, rerun all cases above → identical out and flags, normal latency 15.

Source files
------------

// File: rtl/fp_mul_seq_if.sv
// Request/result bundle shared by the sequential FP multiplier and its issuer.
// Same act/done shape as the sequential divider so the FPU can issue to either unit.
interface fp_mul_seq_if #(
    parameter int unsigned W = 32
);
    logic         act;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [2:0]   round_m;
    logic [W-1:0] out;
    logic         done;
    logic         ov;
    logic         un;
    logic         inv;
    logic         inexact;

    modport master (
        output act, in1, in2, round_m,
        input  out, done, ov, un, inv, inexact
    );

    modport slave (
        input  act, in1, in2, round_m,
        output out, done, ov, un, inv, inexact
    );
endinterface

// File: rtl/fp_mul_seq.sv
// Iterative IEEE-754 single-precision multiplier: shift-add mantissa loop, normalise, round.
// Define FP_MUL_RADIX4_EN to retire two multiplier bits per MUL cycle (12 iterations).
`ifndef RNe
`define RNe 3'b000
`endif
`ifndef RZ
`define RZ 3'b001
`endif
`ifndef RU
`define RU 3'b010
`endif
`ifndef RD
`define RD 3'b011
`endif
`ifndef RNa
`define RNa 3'b100
`endif

module fp_mul_seq #(
    parameter int unsigned W    = 32,
    parameter int unsigned M    = 22,
    parameter int unsigned E    = 30,
    parameter int unsigned BIAS = 127
) (
    input  logic        clk,
    input  logic        rst,
    fp_mul_seq_if.slave bus
);
    localparam int unsigned EW = E - M;
    localparam int unsigned MW = M + 2;
    localparam int unsigned PW = 2 * MW;
    localparam int unsigned XW = 10;
`ifdef FP_MUL_RADIX4_EN
    localparam int unsigned CW = 4;
    localparam int unsigned SH = 2;
`else
    localparam int unsigned CW = 5;
    localparam int unsigned SH = 1;
`endif
    localparam logic [CW-1:0]        LAST    = CW'(MW / SH - 1);
    localparam logic signed [XW-1:0] EXP_MAX = XW'(2 * BIAS);
    localparam logic signed [XW-1:0] EXP_MIN = XW'(1);
    localparam logic [W-1:0]         QNAN    = {1'b0, {EW{1'b1}}, 1'b1, M'(0)};

    typedef enum logic [2:0] {IDLE, SPECIAL, MUL, NORM, ROUND} state_t;

    state_t               state, state_nxt;
    logic                 rph, spec_f, sp_nan, sp_inf, sign;
    logic [2:0]           rmode;
    logic signed [XW-1:0] ex;
    logic [PW-1:0]        ma, acc, addend_c;
    logic [MW-1:0]        mb, nm;
    logic [CW-1:0]        cnt;
    logic                 g, t, inc_c;
    logic [MW:0]          rsum_c;
    logic [W-1:0]         spec_w;
    logic                 spec_inv;
    logic [W-1:0]         out_q;
    logic                 done_q, ov_q, un_q, inv_q, inx_q;

    // Operand classification on the live inputs (subnormals count as zero)
    logic [EW-1:0] e1_c, e2_c;
    logic          z1_c, z2_c, mx1_c, mx2_c, f1_c, f2_c;
    logic          special_in_c, sp_nan_c, sp_inf_c, accept_c;

    assign e1_c         = bus.in1[E:M+1];
    assign e2_c         = bus.in2[E:M+1];
    assign z1_c         = (e1_c == '0);
    assign z2_c         = (e2_c == '0);
    assign mx1_c        = &e1_c;
    assign mx2_c        = &e2_c;
    assign f1_c         = |bus.in1[M:0];
    assign f2_c         = |bus.in2[M:0];
    assign special_in_c = z1_c | z2_c | mx1_c | mx2_c;
    assign sp_nan_c     = (mx1_c & f1_c) | (mx2_c & f2_c) |
                          (mx1_c & ~f1_c & z2_c) | (mx2_c & ~f2_c & z1_c);
    assign sp_inf_c     = (mx1_c & ~f1_c) | (mx2_c & ~f2_c);
    // The cycle done pulses is still owned by the finished operation
    assign accept_c     = (state == IDLE) && bus.act && !done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_c) state_nxt = special_in_c ? SPECIAL : MUL;
            SPECIAL: state_nxt = ROUND;
            MUL:     if (cnt == LAST) state_nxt = NORM;
            NORM:    state_nxt = ROUND;
            ROUND:   if (spec_f || rph) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Partial-product selection for one MUL step
    always_comb begin
        addend_c = '0;
        if (mb[0]) addend_c = ma;
`ifdef FP_MUL_RADIX4_EN
        if (mb[1]) addend_c = addend_c + (ma << 1);
`endif
    end

    always_comb begin
        inc_c = 1'b0;
        case (rmode)
            `RNe:    inc_c = g & (t | nm[0]);
            `RNa:    inc_c = g;
            `RU:     inc_c = (g | t) & ~sign;
            `RD:     inc_c = (g | t) & sign;
            default: inc_c = 1'b0;
        endcase
        rsum_c = {1'b0, nm} + (MW+1)'(inc_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rph      <= 1'b0;
            spec_f   <= 1'b0;
            sp_nan   <= 1'b0;
            sp_inf   <= 1'b0;
            sign     <= 1'b0;
            rmode    <= '0;
            ex       <= '0;
            ma       <= '0;
            mb       <= '0;
            acc      <= '0;
            cnt      <= '0;
            nm       <= '0;
            g        <= 1'b0;
            t        <= 1'b0;
            spec_w   <= '0;
            spec_inv <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept_c) begin
                    rph    <= 1'b0;
                    spec_f <= special_in_c;
                    sp_nan <= sp_nan_c;
                    sp_inf <= sp_inf_c;
                    sign   <= bus.in1[W-1] ^ bus.in2[W-1];
                    rmode  <= bus.round_m;
                    ex     <= XW'(e1_c) + XW'(e2_c) - XW'(BIAS);
                    ma     <= PW'({1'b1, bus.in1[M:0]});
                    mb     <= {1'b1, bus.in2[M:0]};
                    acc    <= '0;
                    cnt    <= '0;
                end
                SPECIAL: begin
                    spec_inv <= sp_nan;
                    if (sp_nan)      spec_w <= QNAN;
                    else if (sp_inf) spec_w <= {sign, {EW{1'b1}}, (M+1)'(0)};
                    else             spec_w <= {sign, (W-1)'(0)};
                end
                MUL: begin
                    acc <= acc + addend_c;
                    ma  <= ma << SH;
                    mb  <= mb >> SH;
                    cnt <= cnt + CW'(1);
                end
                NORM: begin
                    // Product of two [1,2) significands lies in [1,4)
                    if (acc[PW-1]) begin
                        nm <= acc[PW-1 -: MW];
                        g  <= acc[PW-1-MW];
                        t  <= |acc[PW-2-MW:0];
                        ex <= ex + XW'(1);
                    end else begin
                        nm <= acc[PW-2 -: MW];
                        g  <= acc[PW-2-MW];
                        t  <= |acc[PW-3-MW:0];
                    end
                end
                ROUND: if (!spec_f && !rph) begin
                    rph <= 1'b1;
                    if (rsum_c[MW]) begin
                        nm <= rsum_c[MW:1];
                        ex <= ex + XW'(1);
                    end else begin
                        nm <= rsum_c[MW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Result/flag registers: written once per operation, held until the next one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q  <= '0;
            done_q <= 1'b0;
            ov_q   <= 1'b0;
            un_q   <= 1'b0;
            inv_q  <= 1'b0;
            inx_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == ROUND && spec_f) begin
                out_q  <= spec_w;
                inv_q  <= spec_inv;
                ov_q   <= 1'b0;
                un_q   <= 1'b0;
                inx_q  <= 1'b0;
                done_q <= 1'b1;
            end else if (state == ROUND && rph) begin
                inv_q  <= 1'b0;
                done_q <= 1'b1;
                if (ex > EXP_MAX) begin
                    out_q <= {sign, {EW{1'b1}}, (M+1)'(0)};
                    ov_q  <= 1'b1;
                    un_q  <= 1'b0;
                    inx_q <= 1'b1;
                end else if (ex < EXP_MIN) begin
                    out_q <= {sign, (W-1)'(0)};
                    ov_q  <= 1'b0;
                    un_q  <= 1'b1;
                    inx_q <= 1'b1;
                end else begin
                    out_q <= {sign, ex[EW-1:0], nm[M:0]};
                    ov_q  <= 1'b0;
                    un_q  <= 1'b0;
                    inx_q <= g | t;
                end
            end
        end
    end

    assign bus.out     = out_q;
    assign bus.done    = done_q;
    assign bus.ov      = ov_q;
    assign bus.un      = un_q;
    assign bus.inv     = inv_q;
    assign bus.inexact = inx_q;
endmodule
